// File: rtl/fib_sched_pkg_amisha.sv
// Shared constants, state encoding and range helper for the Fibonacci job scheduler.
package fib_sched_pkg_amisha;

  localparam int NREQ     = 4;    // number of requesters
  localparam int IW       = 5;    // Fibonacci operand index width
  localparam int FW       = 20;   // Fibonacci result width
  localparam int IMAX     = 30;   // largest index whose result fits in FW bits
  localparam int TO_LIMIT = 255;  // watchdog terminal count while waiting on the FSMD
  localparam int IDW      = 2;    // requester id width
  localparam int WDW      = 8;    // watchdog width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  // F(31) and above overflow the result bus, so such indices are rejected up front.
  function automatic logic idx_in_range(input logic [IW-1:0] idx);
    return (idx <= IW'(IMAX));
  endfunction

endpackage

// File: rtl/fib_sched_amisha_arb.sv
// Combinational round-robin arbiter: the first asserted request at or after ptr wins.
module rr_arb_amisha
  import fib_sched_pkg_amisha::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  gnt_id,
  output logic            any_gnt
);

  logic [IDW-1:0] cand;

  // Scan requesters ptr, ptr+1, ... (mod NREQ) and keep the first asserted one.
  always_comb begin
    gnt_id  = '0;
    any_gnt = 1'b0;
    cand    = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = ptr + IDW'(off);
      if (!any_gnt && req[cand]) begin
        gnt_id  = cand;
        any_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fib_sched_amisha.sv
// Arbitrates four requesters onto one shared Fibonacci FSMD, guards the job with a
// watchdog and returns the result with the served requester id.
module fib_sched_amisha
  import fib_sched_pkg_amisha::*;
(
  input  logic                 clk_amisha,
  input  logic                 reset_amisha,
  input  logic [NREQ-1:0]      req_amisha,
  input  logic [NREQ*IW-1:0]   i_req_amisha,
  output logic [NREQ-1:0]      ack_amisha,
  output logic                 done_tick_amisha,
  output logic [IDW-1:0]       done_id_amisha,
  output logic [FW-1:0]        f_amisha,
  output logic                 err_amisha,
  output logic                 fib_start_amisha,
  output logic [IW-1:0]        fib_i_amisha,
  input  logic                 fib_ready_amisha,
  input  logic                 fib_done_tick_amisha,
  input  logic [FW-1:0]        fib_f_amisha
);

  sched_state_e   state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [FW-1:0]  f_q, f_d;
  logic           err_q, err_d;
  logic [IDW-1:0] done_id_q, done_id_d;

  logic [IDW-1:0] gnt_id;
  logic           any_gnt;
  logic [IW-1:0]  gnt_idx;

  rr_arb_amisha u_arb (
    .req     (req_amisha),
    .ptr     (rr_ptr_q),
    .gnt_id  (gnt_id),
    .any_gnt (any_gnt)
  );

  assign gnt_idx = i_req_amisha[int'(gnt_id) * IW +: IW];

  // Result, id and error are only rewritten on the way into RESP, so they hold between jobs.
  assign f_amisha       = f_q;
  assign err_amisha     = err_q;
  assign done_id_amisha = done_id_q;
  assign fib_i_amisha   = idx_q;

  // State and datapath registers; reset abandons any in-flight job.
  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      id_q      <= '0;
      idx_q     <= '0;
      wd_q      <= '0;
      f_q       <= '0;
      err_q     <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      idx_q     <= idx_d;
      wd_q      <= wd_d;
      f_q       <= f_d;
      err_q     <= err_d;
      done_id_q <= done_id_d;
    end
  end

  // Next-state, next-datapath and Moore strobes for the scheduler FSM.
  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    id_d             = id_q;
    idx_d            = idx_q;
    wd_d             = wd_q;
    f_d              = f_q;
    err_d            = err_q;
    done_id_d        = done_id_q;
    fib_start_amisha = 1'b0;
    done_tick_amisha = 1'b0;
    ack_amisha       = '0;

    unique case (state_q)
      IDLE: begin
        if (fib_ready_amisha && any_gnt) begin
          id_d     = gnt_id;
          idx_d    = gnt_idx;
          rr_ptr_d = gnt_id + IDW'(1);
          if (idx_in_range(gnt_idx)) begin
            state_d = ISSUE;
          end else begin
            // Out-of-range index: answer immediately without touching the FSMD.
            f_d       = '0;
            err_d     = 1'b1;
            done_id_d = gnt_id;
            state_d   = RESP;
          end
        end
      end

      ISSUE: begin
        fib_start_amisha = 1'b1;
        wd_d             = '0;
        state_d          = WAIT;
      end

      WAIT: begin
        // A done arriving on the watchdog's last count still wins.
        if (fib_done_tick_amisha) begin
          f_d       = fib_f_amisha;
          err_d     = 1'b0;
          done_id_d = id_q;
          state_d   = RESP;
        end else if (wd_q == WDW'(TO_LIMIT)) begin
          f_d       = '0;
          err_d     = 1'b1;
          done_id_d = id_q;
          state_d   = RESP;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end

      RESP: begin
        done_tick_amisha = 1'b1;
        ack_amisha[id_q] = 1'b1;
        state_d          = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fib_sched_amisha.sv
// Scoreboard bench for fib_sched_amisha with a behavioural Fibonacci FSMD model.
module tb_fib_sched_amisha;
  import fib_sched_pkg_amisha::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req;
  logic [19:0] i_req;
  logic [3:0]  ack;
  logic        done_tick;
  logic [1:0]  done_id;
  logic [19:0] f;
  logic        err;
  logic        fib_start;
  logic [4:0]  fib_i;
  logic        fib_ready;
  logic        fib_done;
  logic [19:0] fib_f;

  always #5 clk = ~clk;

  fib_sched_amisha dut (
    .clk_amisha           (clk),
    .reset_amisha         (rst_n),
    .req_amisha           (req),
    .i_req_amisha         (i_req),
    .ack_amisha           (ack),
    .done_tick_amisha     (done_tick),
    .done_id_amisha       (done_id),
    .f_amisha             (f),
    .err_amisha           (err),
    .fib_start_amisha     (fib_start),
    .fib_i_amisha         (fib_i),
    .fib_ready_amisha     (fib_ready),
    .fib_done_tick_amisha (fib_done),
    .fib_f_amisha         (fib_f)
  );

  // ---------------- Fibonacci FSMD model ----------------
  int          lat  = 4;     // cycles from start acceptance to done
  bit          hang = 1'b0;  // when set, the model ignores starts and never answers
  logic        busy;
  logic [8:0]  cnt;

  function automatic logic [19:0] fib(input logic [4:0] n);
    logic [31:0] a, b, t;
    a = 0;
    b = 1;
    for (int k = 0; k < int'(n); k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a[19:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      cnt      <= '0;
      fib_f    <= '0;
      fib_done <= 1'b0;
    end else begin
      fib_done <= 1'b0;
      if (busy) begin
        if (cnt == 9'd1) begin
          busy     <= 1'b0;
          fib_done <= 1'b1;
        end else begin
          cnt <= cnt - 9'd1;
        end
      end else if (fib_start && !hang) begin
        busy  <= 1'b1;
        cnt   <= 9'(lat);
        fib_f <= fib(fib_i);
      end
    end
  end

  assign fib_ready = !busy;

  // ---------------- scoreboard and checking ----------------
  typedef struct {
    logic [1:0]  id;
    logic [19:0] f;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   start_cnt = 0;
  int   start_cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic [4:0] last_fib_i = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [19:0] fv, input logic e);
    exp_t x;
    x.id  = id;
    x.f   = fv;
    x.err = e;
    sb.push_back(x);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (fib_start) begin
        start_cnt  <= start_cnt + 1;
        start_cyc  <= cyc;
        last_fib_i <= fib_i;
      end
      if (done_tick) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          chk("done_id", 32'(done_id), 32'(sb[0].id));
          chk("f", 32'(f), 32'(sb[0].f));
          chk("err", 32'(err), 32'(sb[0].err));
          chk("ack", 32'(ack), 32'(4'b0001 << sb[0].id));
          void'(sb.pop_front());
        end
      end
    end
  end

  // Run until every expected response has been seen, dropping acknowledged requests.
  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      req = req & ~ack;
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_budget", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_ack"}, 32'(ack), 32'd0);
    chk({pfx, "_done_tick"}, 32'(done_tick), 32'd0);
    chk({pfx, "_done_id"}, 32'(done_id), 32'd0);
    chk({pfx, "_f"}, 32'(f), 32'd0);
    chk({pfx, "_err"}, 32'(err), 32'd0);
    chk({pfx, "_fib_start"}, 32'(fib_start), 32'd0);
    chk({pfx, "_fib_i"}, 32'(fib_i), 32'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int sc0;
    int rc;
    int dc0;
    int n;

    req   = '0;
    i_req = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Fairness: all four requesting, two full rounds in order 0..3.
    for (int r = 0; r < 2; r++) begin
      i_req = {5'd4, 5'd3, 5'd2, 5'd1};
      push(2'd0, 20'd1, 1'b0);
      push(2'd1, 20'd1, 1'b0);
      push(2'd2, 20'd2, 1'b0);
      push(2'd3, 20'd3, 1'b0);
      req = 4'b1111;
      drain(200);
    end

    // Single request, index 8, with latency check from grant.
    lat   = 4;
    i_req = 20'd8;
    sc0   = start_cnt;
    rc    = cyc;
    push(2'd0, 20'd21, 1'b0);
    req = 4'b0001;
    drain(100);
    chk("single_starts", 32'(start_cnt - sc0), 32'd1);
    chk("single_fib_i", 32'(last_fib_i), 32'd8);
    chk("single_latency", 32'(done_cyc - rc), 32'(lat + 3));

    // Largest in-range index.
    i_req = 20'd30;
    push(2'd0, 20'd832040, 1'b0);
    req = 4'b0001;
    drain(100);

    // Out-of-range index on requester 2: immediate error, no FSMD start.
    i_req = {5'd0, 5'd31, 5'd0, 5'd0};
    sc0   = start_cnt;
    rc    = cyc;
    push(2'd2, 20'd0, 1'b1);
    req = 4'b0100;
    drain(50);
    chk("oor_starts", 32'(start_cnt - sc0), 32'd0);
    chk("oor_latency", 32'(done_cyc - rc), 32'd1);
    repeat (5) @(negedge clk);
    chk("hold_done_id", 32'(done_id), 32'd2);
    chk("hold_err", 32'(err), 32'd1);
    chk("hold_f", 32'(f), 32'd0);

    // Watchdog timeout; request dropped right after grant.
    hang  = 1'b1;
    i_req = {5'd0, 5'd0, 5'd7, 5'd0};
    push(2'd1, 20'd0, 1'b1);
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    drain(400);
    chk("timeout_latency", 32'(done_cyc - start_cyc), 32'd257);
    hang = 1'b0;

    // Next request after a timeout is served normally.
    i_req = {5'd10, 5'd0, 5'd0, 5'd0};
    push(2'd3, 20'd55, 1'b0);
    req = 4'b1000;
    drain(100);

    // Done lands on the watchdog's last count: done wins.
    lat   = 255;
    i_req = 20'd12;
    push(2'd0, 20'd144, 1'b0);
    req = 4'b0001;
    drain(400);
    chk("collision_latency", 32'(done_cyc - start_cyc), 32'd257);

    // Reset while waiting on the FSMD.
    lat   = 20;
    i_req = {5'd0, 5'd0, 5'd10, 5'd0};
    sc0   = start_cnt;
    req   = 4'b0010;
    n     = 0;
    while (start_cnt == sc0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rst_job_started", 32'(start_cnt - sc0), 32'd1);
    req = '0;
    repeat (3) @(negedge clk);
    dc0   = done_cnt;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - dc0), 32'd0);

    // Fresh job after the abandoned one.
    lat   = 4;
    i_req = {5'd0, 5'd0, 5'd5, 5'd0};
    push(2'd1, 20'd5, 1'b0);
    req = 4'b0010;
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fib_sched_amisha.md
FIB_SCHED_AMISHA -- requirements
Module: fib_sched_amisha

Interface
REQ-001 SHALL have these ports: clk_amisha, input, 1, single clock; all logic on the rising edge.
REQ-002 SHALL have these ports: reset_amisha, input, 1, asynchronous, active-low reset.
REQ-003 SHALL have these ports: req_amisha, input, 4, per-requester level request; bit k belongs to requester k.
REQ-004 SHALL have these ports: i_req_amisha, input, 20, packed operand indices; bits [5k+4:5k] belong to requester k.
REQ-005 SHALL have these ports: ack_amisha, output, 4, one-cycle one-hot pulse to the served requester.
REQ-006 SHALL have these ports: done_tick_amisha, output, 1, one-cycle pulse; the result bus is valid in that cycle.
REQ-007 SHALL have these ports: done_id_amisha, output, 2, served requester index.
REQ-008 SHALL have these ports: f_amisha, output, 20, result.
REQ-009 SHALL have these ports: err_amisha, output, 1, error flag, valid with done_tick_amisha.
REQ-010 SHALL have these ports, which connect to the shared Fibonacci FSMD: fib_start_amisha (out, 1), fib_i_amisha (out, 5), fib_ready_amisha (in, 1), fib_done_tick_amisha (in, 1), fib_f_amisha (in, 20).

Function
REQ-011 SHALL implement a state machine with four states: IDLE, ISSUE, WAIT and RESP.
REQ-012 In IDLE, SHALL select a winner when fib_ready_amisha=1 and any req_amisha bit is set.
- The winner is chosen round-robin, starting the search at pointer rr_ptr.
- The winner id and its 5-bit index are latched.
- The next state is ISSUE.
REQ-013 SHALL update rr_ptr to (winner+1) mod 4 on every grant.
REQ-014 SHALL route an out-of-range request (latched index >30) from IDLE directly to RESP with err_amisha=1 and f_amisha=0; fib_start_amisha SHALL NOT pulse. (F(31) overflows 20 bits.)
REQ-015 In ISSUE, SHALL assert fib_start_amisha for exactly one cycle, with fib_i_amisha equal to the latched index, then go to WAIT.
REQ-016 In WAIT, SHALL count cycles with an 8-bit watchdog cleared on entry.
- On fib_done_tick_amisha: latch fib_f_amisha, set err=0, go to RESP.
- If the watchdog reaches 255 first: f=0, err=1, go to RESP.
REQ-017 When fib_done_tick_amisha and watchdog=255 occur in the same cycle, SHALL give done priority (err=0, result latched).
REQ-018 In RESP, SHALL pulse done_tick_amisha and ack_amisha[id] for one cycle, then return to IDLE.
REQ-019 SHALL hold f_amisha, done_id_amisha and err_amisha until the next RESP.
REQ-020 Latency from grant to done_tick_amisha SHALL be fib latency + 3 cycles for in-range requests and 1 cycle for out-of-range requests.
REQ-021 Requesters SHALL drop req within one cycle of ack; a request still high in IDLE re-arbitrates as a new request.
REQ-022 Deasserting req after grant SHALL NOT abort the job; the result is still delivered with its done_id_amisha.
REQ-023 SHALL ignore fib_done_tick_amisha outside WAIT.
REQ-024 fib_i_amisha SHALL equal the latched index in every state (glitch-free).

Reset
REQ-025 While reset_amisha=0, SHALL immediately set state=IDLE, rr_ptr=0, watchdog=0.
- All outputs return to 0: ack, done_tick, done_id, f, err, fib_start, fib_i.
REQ-026 Reset mid-operation SHALL abandon the in-flight job without emitting done_tick_amisha.
- The external FSMD is reset by the same reset_amisha.

Structure
REQ-027 Shared package fib_sched_pkg_amisha SHALL hold the constants and the state encoding:
- NREQ=4, IW=5, FW=20, IMAX=30, TO_LIMIT=255.
- State encoding: IDLE=0, ISSUE=1, WAIT=2, RESP=3.
REQ-028 Round-robin selection SHALL be one combinational sub-module, rr_arb_amisha, with inputs req[3:0] and ptr[1:0] and outputs gnt_id[1:0] and any_gnt.
REQ-029 The Fibonacci FSMD SHALL NOT be instantiated inside; the top level connects it.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Single request: req=0001, index=8 -> one fib_start pulse with fib_i=8; done_tick, f=21, id=0, err=0, ack=0001.
- Boundary: index=30 -> f=832040, err=0; index=31 -> done_tick 1 cycle after grant, err=1, f=0, no fib_start.
- Fairness: req=1111 with indices 1,2,3,4 held -> service order 0,1,2,3, f=1,1,2,3; a repeat round starts again at 0.
- Timeout: FSMD model never raises done -> done_tick 255 cycles into WAIT, err=1; next request is served normally.
- Reset in WAIT: reset_amisha low for 1 cycle -> all outputs 0, no done_tick; a later request index=5 -> f=5.
- Collision: done and watchdog=255 in the same cycle -> err=0, f latched.
